// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation classes and the
// main control bundle carried from ID into EX.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src;
      logic       branch;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_main_decoder.sv
// Main control decoder: opcode to control bundle, plus whether the
// instruction reads rt as a source operand.
module main_decoder
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   output ctrl_t      ctrl,
   output logic       uses_rt
);

   always_comb begin
      ctrl    = '0;
      uses_rt = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            ctrl.alu_op    = ALU_OP_FUNCT;
            uses_rt        = 1'b1;
         end
         OP_LW: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.alu_op     = ALU_OP_ADD;
         end
         OP_SW: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
            uses_rt        = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_OP_SUB;
            uses_rt     = 1'b1;
         end
         OP_ADDI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode back half and ID/EX pipeline register: operand bypass, $zero
// forcing, load-use hazard detection and stall/flush bubble insertion.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [31:0]            id_instr,
   input  logic [31:0]            id_pc_plus4,
   output logic [4:0]             read_reg1,
   output logic [4:0]             read_reg2,
   input  logic [31:0]            rf_data1,
   input  logic [31:0]            rf_data2,
   input  logic                   wb_reg_write,
   input  logic [4:0]             wb_write_reg,
   input  logic [31:0]            wb_write_data,
   input  logic                   flush,
   output logic                   stall,
   output logic                   ex_valid,
   output logic                   ex_illegal,
   output logic [31:0]            ex_pc_plus4,
   output logic [31:0]            ex_rs_data,
   output logic [31:0]            ex_rt_data,
   output logic [31:0]            ex_imm,
   output logic [4:0]             ex_rs,
   output logic [4:0]             ex_rt,
   output logic [4:0]             ex_rd,
   output logic [4:0]             ex_shamt,
   output logic [5:0]             ex_funct,
   output logic                   ex_reg_write,
   output logic                   ex_mem_read,
   output logic                   ex_mem_write,
   output logic                   ex_mem_to_reg,
   output logic                   ex_reg_dst,
   output logic                   ex_alu_src,
   output logic                   ex_branch,
   output logic [1:0]             ex_alu_op,
   output logic [STALL_CNT_W-1:0] stall_count
);

   logic [4:0]  rs, rt;
   logic [31:0] rs_val, rt_val;
   ctrl_t       dec_ctrl, ld_ctrl;
   logic        uses_rt;

   assign rs        = id_instr[25:21];
   assign rt        = id_instr[20:16];
   assign read_reg1 = rs;
   assign read_reg2 = rt;

   main_decoder u_main_decoder (
      .opcode  (id_instr[31:26]),
      .ctrl    (dec_ctrl),
      .uses_rt (uses_rt)
   );

   // The register file does not protect $zero, so it is forced here ahead of the bypass.
   always_comb begin
      rs_val = rf_data1;
      if (rs == 5'd0)
         rs_val = '0;
      else if (wb_reg_write && wb_write_reg == rs)
         rs_val = wb_write_data;

      rt_val = rf_data2;
      if (rt == 5'd0)
         rt_val = '0;
      else if (wb_reg_write && wb_write_reg == rt)
         rt_val = wb_write_data;
   end

   assign ld_ctrl = id_valid ? dec_ctrl : '0;

   assign stall = id_valid && ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == rs) || (uses_rt && ex_rt == rt)) && !flush;

   // Reset, flush and stall all load the same all-zero bubble image.
   always_ff @(posedge clk) begin
      if (!rst || flush || stall) begin
         ex_valid      <= 1'b0;
         ex_illegal    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_dst    <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_branch     <= 1'b0;
         ex_alu_op     <= '0;
         ex_pc_plus4   <= '0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm        <= '0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_rd         <= '0;
         ex_shamt      <= '0;
         ex_funct      <= '0;
      end else begin
         ex_valid      <= id_valid;
         ex_illegal    <= ld_ctrl.illegal;
         ex_reg_write  <= ld_ctrl.reg_write;
         ex_mem_read   <= ld_ctrl.mem_read;
         ex_mem_write  <= ld_ctrl.mem_write;
         ex_mem_to_reg <= ld_ctrl.mem_to_reg;
         ex_reg_dst    <= ld_ctrl.reg_dst;
         ex_alu_src    <= ld_ctrl.alu_src;
         ex_branch     <= ld_ctrl.branch;
         ex_alu_op     <= ld_ctrl.alu_op;
         ex_pc_plus4   <= id_pc_plus4;
         ex_rs_data    <= rs_val;
         ex_rt_data    <= rt_val;
         ex_imm        <= {{16{id_instr[15]}}, id_instr[15:0]};
         ex_rs         <= rs;
         ex_rt         <= rt;
         ex_rd         <= id_instr[15:11];
         ex_shamt      <= id_instr[10:6];
         ex_funct      <= id_instr[5:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         stall_count <= '0;
      else if (stall && stall_count != '1)
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: per-cycle stimulus rows push the expected
// EX image, which is popped and compared one clock later.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_instr, id_pc_plus4;
   logic [4:0]  read_reg1, read_reg2;
   logic [31:0] rf_data1, rf_data2;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        flush, stall;
   logic        ex_valid, ex_illegal;
   logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [5:0]  ex_funct;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
   logic        ex_reg_dst, ex_alu_src, ex_branch;
   logic [1:0]  ex_alu_op;
   logic [1:0]  stall_count;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.STALL_CNT_W(2)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc_plus4(id_pc_plus4), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
      .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
      .stall(stall), .ex_valid(ex_valid), .ex_illegal(ex_illegal),
      .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_dst(ex_reg_dst),
      .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v, ill;
      logic [6:0]  c;   // reg_write mem_read mem_write mem_to_reg reg_dst alu_src branch
      logic [1:0]  op;
      logic [31:0] pc, rsd, rtd, imm;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
   } exp_t;

   typedef struct {
      logic        r, v;
      logic [31:0] ins;
      logic        fl, wbw;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        st;
      exp_t        e;
      int          cnt;
   } row_t;

   localparam exp_t BUB = '0;
   localparam logic [6:0] C_R = 7'b1000100, C_LW = 7'b1101010, C_SW = 7'b0010010;
   localparam logic [6:0] C_BEQ = 7'b0000001, C_ADDI = 7'b1000010;

   localparam logic [31:0] ADD     = 32'h00221820; // add  $3,$1,$2
   localparam logic [31:0] ADD0    = 32'h00021820; // add  $3,$0,$2
   localparam logic [31:0] LW5     = 32'h8C250004; // lw   $5,4($1)
   localparam logic [31:0] LW0     = 32'h8C200004; // lw   $0,4($1)
   localparam logic [31:0] USE_RS  = 32'h00A73020; // add  $6,$5,$7
   localparam logic [31:0] USE_RT  = 32'h00E53020; // add  $6,$7,$5
   localparam logic [31:0] USE_Z   = 32'h00073020; // add  $6,$0,$7
   localparam logic [31:0] ADDI5   = 32'h20050007; // addi $5,$0,7
   localparam logic [31:0] ILL     = 32'hFC221234;
   localparam logic [31:0] SW      = 32'hAC220008; // sw   $2,8($1)
   localparam logic [31:0] LWN     = 32'h8C22FFFC; // lw   $2,-4($1)
   localparam logic [31:0] BEQ     = 32'h10220003; // beq  $1,$2,3

   exp_t sb[$];

   function automatic exp_t mk(input logic [31:0] ins, input logic v, input logic ill,
                               input logic [6:0] c, input logic [1:0] op,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [31:0] imm);
      mk = '{v, ill, c, op, ~ins, rsd, rtd, imm,
             ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0]};
   endfunction

   function automatic row_t rw(input logic r, input logic v, input logic [31:0] ins,
                               input logic fl, input logic wbw, input logic [4:0] wr,
                               input logic [31:0] wd, input logic st, input exp_t e,
                               input int cnt);
      rw = '{r, v, ins, fl, wbw, wr, wd, st, e, cnt};
   endfunction

   function automatic exp_t act();
      act = {ex_valid, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_mem_to_reg, ex_reg_dst, ex_alu_src, ex_branch, ex_alu_op,
             ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
             ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct};
   endfunction

   task automatic apply(input row_t t);
      rst = t.r; id_valid = t.v; id_instr = t.ins; id_pc_plus4 = ~t.ins;
      flush = t.fl; wb_reg_write = t.wbw; wb_write_reg = t.wr; wb_write_data = t.wd;
   endtask

   task automatic test_reset();
      row_t q[$];
      exp_t e;
      q.push_back(rw(0, 1, ADD, 0, 0, 0, 0, 0, BUB, 0));
      q.push_back(rw(1, 1, ADD, 0, 0, 0, 0, 0, mk(ADD, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h1820), 0));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL reset_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         checks++;
         if ({read_reg1, read_reg2} !== q[i].ins[25:16]) begin errors++; $display("FAIL reset_rdaddr[%0d] got %h exp %h", i, {read_reg1, read_reg2}, q[i].ins[25:16]); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL reset_ex[%0d] got %h exp %h", i, act(), e); end
         checks++;
         if (stall_count !== 2'(q[i].cnt)) begin errors++; $display("FAIL reset_cnt[%0d] got %0d exp %0d", i, stall_count, q[i].cnt); end
      end
   endtask

   task automatic test_bypass();
      row_t q[$];
      exp_t e;
      q.push_back(rw(1, 1, ADD, 0, 1, 5'd1, 32'hDEADBEEF, 0, mk(ADD, 1, 0, C_R, 2'b10, 32'hDEADBEEF, 32'h22, 32'h1820), 0));
      q.push_back(rw(1, 1, ADD, 0, 1, 5'd2, 32'hCAFEF00D, 0, mk(ADD, 1, 0, C_R, 2'b10, 32'h11, 32'hCAFEF00D, 32'h1820), 0));
      q.push_back(rw(1, 1, ADD0, 0, 1, 5'd0, 32'h5, 0, mk(ADD0, 1, 0, C_R, 2'b10, 32'h0, 32'h22, 32'h1820), 0));
      q.push_back(rw(1, 1, ADD, 0, 0, 5'd1, 32'hDEADBEEF, 0, mk(ADD, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h1820), 0));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL bypass_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL bypass_ex[%0d] got %h exp %h", i, act(), e); end
      end
   endtask

   task automatic test_load_use();
      row_t q[$];
      exp_t e;
      exp_t e_lw = mk(LW5, 1, 0, C_LW, 2'b00, 32'h11, 32'h22, 32'h4);
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, 0));
      q.push_back(rw(1, 1, USE_RS, 0, 0, 0, 0, 1, BUB, 1));
      q.push_back(rw(1, 1, USE_RS, 0, 0, 0, 0, 0, mk(USE_RS, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h3020), 1));
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, 1));
      q.push_back(rw(1, 1, ADDI5, 0, 0, 0, 0, 0, mk(ADDI5, 1, 0, C_ADDI, 2'b00, 32'h0, 32'h22, 32'h7), 1));
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, 1));
      q.push_back(rw(1, 1, USE_RT, 0, 0, 0, 0, 1, BUB, 2));
      q.push_back(rw(1, 1, USE_RT, 0, 0, 0, 0, 0, mk(USE_RT, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h3020), 2));
      q.push_back(rw(1, 1, LW0, 0, 0, 0, 0, 0, mk(LW0, 1, 0, C_LW, 2'b00, 32'h11, 32'h0, 32'h4), 2));
      q.push_back(rw(1, 1, USE_Z, 0, 0, 0, 0, 0, mk(USE_Z, 1, 0, C_R, 2'b10, 32'h0, 32'h22, 32'h3020), 2));
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, 2));
      q.push_back(rw(1, 0, USE_RS, 0, 0, 0, 0, 0, mk(USE_RS, 0, 0, 7'b0, 2'b00, 32'h11, 32'h22, 32'h3020), 2));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL loaduse_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL loaduse_ex[%0d] got %h exp %h", i, act(), e); end
         checks++;
         if (stall_count !== 2'(q[i].cnt)) begin errors++; $display("FAIL loaduse_cnt[%0d] got %0d exp %0d", i, stall_count, q[i].cnt); end
      end
   endtask

   task automatic test_flush();
      row_t q[$];
      exp_t e;
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, mk(LW5, 1, 0, C_LW, 2'b00, 32'h11, 32'h22, 32'h4), 2));
      q.push_back(rw(1, 1, USE_RS, 1, 0, 0, 0, 0, BUB, 2));
      q.push_back(rw(1, 1, ADD, 1, 0, 0, 0, 0, BUB, 2));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL flush_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL flush_ex[%0d] got %h exp %h", i, act(), e); end
         checks++;
         if (stall_count !== 2'(q[i].cnt)) begin errors++; $display("FAIL flush_cnt[%0d] got %0d exp %0d", i, stall_count, q[i].cnt); end
      end
   endtask

   task automatic test_decode();
      row_t q[$];
      exp_t e;
      q.push_back(rw(1, 1, ILL, 0, 0, 0, 0, 0, mk(ILL, 1, 1, 7'b0, 2'b00, 32'h11, 32'h22, 32'h1234), 2));
      q.push_back(rw(1, 1, SW, 0, 0, 0, 0, 0, mk(SW, 1, 0, C_SW, 2'b00, 32'h11, 32'h22, 32'h8), 2));
      q.push_back(rw(1, 1, BEQ, 0, 0, 0, 0, 0, mk(BEQ, 1, 0, C_BEQ, 2'b01, 32'h11, 32'h22, 32'h3), 2));
      q.push_back(rw(1, 1, LWN, 0, 0, 0, 0, 0, mk(LWN, 1, 0, C_LW, 2'b00, 32'h11, 32'h22, 32'hFFFFFFFC), 2));
      q.push_back(rw(1, 1, ADD, 0, 0, 0, 0, 1, BUB, 3));
      q.push_back(rw(1, 1, ADD, 0, 0, 0, 0, 0, mk(ADD, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h1820), 3));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL decode_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL decode_ex[%0d] got %h exp %h", i, act(), e); end
         checks++;
         if (stall_count !== 2'(q[i].cnt)) begin errors++; $display("FAIL decode_cnt[%0d] got %0d exp %0d", i, stall_count, q[i].cnt); end
      end
   endtask

   task automatic test_saturation();
      row_t q[$];
      exp_t e;
      exp_t e_lw = mk(LW5, 1, 0, C_LW, 2'b00, 32'h11, 32'h22, 32'h4);
      q.push_back(rw(0, 1, ADD, 0, 0, 0, 0, 0, BUB, 0));
      for (int k = 1; k <= 5; k++) begin
         q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, (k - 1 > 3) ? 3 : k - 1));
         q.push_back(rw(1, 1, USE_RS, 0, 0, 0, 0, 1, BUB, (k > 3) ? 3 : k));
      end
      // reset arriving while a stall is asserted
      q.push_back(rw(1, 1, LW5, 0, 0, 0, 0, 0, e_lw, 3));
      q.push_back(rw(0, 1, USE_RS, 0, 0, 0, 0, 1, BUB, 0));
      q.push_back(rw(1, 1, USE_RS, 0, 0, 0, 0, 0, mk(USE_RS, 1, 0, C_R, 2'b10, 32'h11, 32'h22, 32'h3020), 0));
      foreach (q[i]) begin
         apply(q[i]);
         #1;
         checks++;
         if (stall !== q[i].st) begin errors++; $display("FAIL sat_stall[%0d] got %b exp %b", i, stall, q[i].st); end
         sb.push_back(q[i].e);
         @(posedge clk); @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (act() !== e) begin errors++; $display("FAIL sat_ex[%0d] got %h exp %h", i, act(), e); end
         checks++;
         if (stall_count !== 2'(q[i].cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_count, q[i].cnt); end
      end
   endtask

   initial begin
      rst = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc_plus4 = '0;
      rf_data1 = 32'h11; rf_data2 = 32'h22;
      wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0; flush = 1'b0;
      @(posedge clk); @(negedge clk);
      test_reset();
      test_bypass();
      test_load_use();
      test_flush();
      test_decode();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-stage back half plus ID/EX pipeline register.
- Drives the register file read addresses from the IF/ID instruction and consumes the register file read data.
- Bypasses same-cycle write-back data and forces $zero to read as 0.
- Detects load-use hazards, decodes main control, and registers everything for EX with stall/flush bubbles and a saturating stall counter.

Parameters:
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-low reset (0 = reset)
- id_valid  input  1  IF/ID holds a real instruction
- id_instr  input  32  IF/ID instruction
- id_pc_plus4  input  32  IF/ID PC+4
- read_reg1  output  5  to register file: id_instr[25:21]
- read_reg2  output  5  to register file: id_instr[20:16]
- rf_data1  input  32  register file read_data1
- rf_data2  input  32  register file read_data2
- wb_reg_write  input  1  write-back enable (same signal as the register file reg_write)
- wb_write_reg  input  5  write-back destination
- wb_write_data  input  32  write-back data
- flush  input  1  EX branch taken; kill the ID instruction
- stall  output  1  load-use stall to PC and IF/ID (hold)
- ex_valid, ex_illegal  output  1 each  EX instruction valid / undecodable opcode
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  output  32 each  registered operands; imm is sign-extended
- ex_rs, ex_rt, ex_rd, ex_shamt  output  5 each  registered fields
- ex_funct  output  6  registered funct
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_dst, ex_alu_src, ex_branch  output  1 each  registered control
- ex_alu_op  output  2  00 add, 01 sub, 10 funct
- stall_count  output  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- read_reg1/read_reg2 are combinational from id_instr.
- Operand select, rs shown; rt is identical with read_reg2/rf_data2:
  - rs==0 -> 0. The register file does not protect $zero.
  - else if wb_reg_write && wb_write_reg==rs -> wb_write_data (same-cycle write-then-read bypass).
  - else rf_data1.
- Decode (combinational):
  - 000000 R: reg_write, reg_dst, alu_op=10.
  - 100011 lw: reg_write, mem_read, mem_to_reg, alu_src, alu_op=00.
  - 101011 sw: mem_write, alu_src, alu_op=00.
  - 000100 beq: branch, alu_op=01.
  - 001000 addi: reg_write, alu_src, alu_op=00.
  - Other: all control 0, illegal=1.
- uses_rt = R, sw, beq.
- stall:
  - Condition: id_valid && ex_valid && ex_mem_read && ex_rt!=0 && (ex_rt==rs || (uses_rt && ex_rt==rt)) && !flush.
  - Combinational; no dependence on stall itself.
- Register update at posedge clk, priority high to low:
  1. rst==0: every ex_* output 0, stall_count 0.
  2. flush: bubble.
  3. stall: bubble; the ID instruction is held upstream and re-evaluated next cycle.
  4. Otherwise: load decoded/selected values; ex_valid=id_valid.
     - If id_valid==0, all control and ex_illegal are forced 0; data loads anyway.
- Bubble: ex_valid=0, ex_illegal=0, all control 0, all data/field outputs 0.
- stall_count increments on each cycle where stall==1 and rst==1; it saturates at all-ones.
- Latency: ID to EX outputs, 1 cycle; stall is 0-cycle combinational.
- Reset mid-stall: the next cycle shows a bubble and stall=0, since ex_valid=0.
- Flush with a hazard present: stall=0, bubble loaded, stall_count unchanged.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI.
  - ALU_OP_ADD/SUB/FUNCT codes.
  - Control bundle struct ctrl_t (reg_write…alu_op, illegal).
- One sub-module, main_decoder: opcode -> ctrl_t plus uses_rt, purely combinational.
- Bypass, hazard and pipeline-register logic stay in id_ex_stage.

Test Plan:
- Reset: rst=0 one cycle with id_valid=1 add $3,$1,$2 -> all ex_* 0, stall_count 0; rst=1 -> next cycle ex_valid=1, ex_reg_write=1, ex_rd=3, ex_alu_op=10.
- Bypass: wb_reg_write=1, wb_write_reg=1, wb_write_data=0xDEADBEEF, rf_data1=0x11, instr add $3,$1,$2 -> ex_rs_data=0xDEADBEEF; with wb_write_reg=0 and write data 5 to $0 -> ex_rs_data=0.
- Load-use: lw $5,4($1) then add $6,$5,$7 -> stall=1 one cycle, bubble (ex_valid=0), stall_count=1; next cycle the add issues, ex_rs=5. Same with addi $6,$0,$5-as-rt (rt unused) -> no stall.
- Flush priority: lw $5 in EX, dependent add in ID, flush=1 -> stall=0, bubble, stall_count unchanged.
- Illegal: opcode 0x3F valid -> ex_valid=1, ex_illegal=1, all control 0; sw $2,8($1) -> ex_mem_write=1, ex_alu_src=1, ex_imm=0x00000008; imm 0xFFFC -> 0xFFFFFFFC.
- Saturation: with STALL_CNT_W=2, force 5 consecutive stall cycles -> stall_count reads 1,2,3,3,3.
